// File: rtl/ack_stream_fifo.sv
// ack_stream_fifo: elastic buffer between a dataflow graph's out operator and a consumer.
// Both sides use a one-outstanding req/ack pulse handshake. Upstream, this block is the
// requester; downstream, it is the responder.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   din_req       request to upstream; high means one slot is reserved
//   din_ack, din  upstream one-cycle ack pulse and its data word
//   dout_req      consumer request
//   dout_ack      one-cycle ack pulse to consumer
//   dout          registered output word, held between acks
//   level         occupancy 0..depth; empty and full are decoded from it
//
// Optional build macro ACK_STREAM_FIFO_STATS_EN adds the push_count, pop_count and
// peak_level outputs after full.
module ack_stream_fifo #(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 8,
  parameter int unsigned addr_width = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  din_req,
  input  logic                  din_ack,
  input  logic [data_width-1:0] din,
  input  logic                  dout_req,
  output logic                  dout_ack,
  output logic [data_width-1:0] dout,
  output logic [addr_width:0]   level,
  output logic                  empty,
  output logic                  full
`ifdef ACK_STREAM_FIFO_STATS_EN
  ,
  output logic [31:0]           push_count,
  output logic [31:0]           pop_count,
  output logic [addr_width:0]   peak_level
`endif
);

  localparam logic [addr_width:0]   LevelMax = (addr_width + 1)'(depth);
  localparam logic [addr_width:0]   LevelOne = (addr_width + 1)'(1);
  localparam logic [addr_width-1:0] PtrOne   = addr_width'(1);

  logic [data_width-1:0] mem_q [depth];
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   level_q, level_d;
  logic                  din_req_q, din_req_d;
  logic                  dout_ack_q, dout_ack_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  push, pop;

  always_comb begin
    // An ack only counts while our request is outstanding; stray acks are dropped.
    push = din_ack & din_req_q;
    // dout_ack gates itself so the consumer sees at most one word per two cycles.
    pop  = dout_req & ~dout_ack_q & (level_q != '0);

    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LevelOne;
    end else if (pop && !push) begin
      level_d = level_q - LevelOne;
    end

    // Request is raised against the post-edge level, so a same-edge pop frees a slot.
    // A raised request keeps its reserved slot until acked.
    din_req_d = din_req_q;
    if (push) begin
      din_req_d = 1'b0;
    end else if (!din_req_q && (level_d < LevelMax)) begin
      din_req_d = 1'b1;
    end

    dout_ack_d = pop;
    dout_d     = pop ? mem_q[rd_ptr_q] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      din_req_q  <= 1'b0;
      dout_ack_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      din_req_q  <= din_req_d;
      dout_ack_q <= dout_ack_d;
      dout_q     <= dout_d;
    end
  end

  // Storage carries no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign din_req  = din_req_q;
  assign dout_ack = dout_ack_q;
  assign dout     = dout_q;
  assign level    = level_q;
  assign empty    = (level_q == '0);
  assign full     = (level_q == LevelMax);

`ifdef ACK_STREAM_FIFO_STATS_EN
  logic [31:0]         push_count_q, pop_count_q;
  logic [addr_width:0] peak_level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      push_count_q <= '0;
      pop_count_q  <= '0;
      peak_level_q <= '0;
    end else begin
      if (push) push_count_q <= push_count_q + 32'd1;
      if (pop) pop_count_q <= pop_count_q + 32'd1;
      if (level_d > peak_level_q) peak_level_q <= level_d;
    end
  end

  assign push_count = push_count_q;
  assign pop_count  = pop_count_q;
  assign peak_level = peak_level_q;
`endif

  // The reservation scheme makes these unreachable; they guard against logic regressions.
  overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (level_q == LevelMax)))
    else $error("ack_stream_fifo: push into full buffer");

  underflow_a : assert property (@(posedge clk) disable iff (rst)
    !(pop && !push && (level_q == '0)))
    else $error("ack_stream_fifo: pop from empty buffer");

endmodule

// File: tb/tb_ack_stream_fifo.sv
module tb_ack_stream_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          din_req;
  logic          din_ack;
  logic [DW-1:0] din;
  logic          dout_req;
  logic          dout_ack;
  logic [DW-1:0] dout;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
`ifdef ACK_STREAM_FIFO_STATS_EN
  logic [31:0]   push_count;
  logic [31:0]   pop_count;
  logic [AW:0]   peak_level;
`endif

  ack_stream_fifo #(
    .data_width(DW),
    .depth     (8),
    .addr_width(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_req   (din_req),
    .din_ack   (din_ack),
    .din       (din),
    .dout_req  (dout_req),
    .dout_ack  (dout_ack),
    .dout      (dout),
    .level     (level),
    .empty     (empty),
    .full      (full)
`ifdef ACK_STREAM_FIFO_STATS_EN
    ,
    .push_count(push_count),
    .pop_count (pop_count),
    .peak_level(peak_level)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int prod_en, cons_en;
  int prod_val, cons_exp, peak_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_ack = 1'b0;
    dout_req = 1'b0;
    din = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock with a bench producer (acks whenever requested) and a consumer that
  // expects a counting sequence.
  task automatic cycle();
    @(negedge clk);
    din_ack  = (prod_en != 0) && din_req;
    din      = DW'(prod_val);
    dout_req = (cons_en != 0);
    @(posedge clk);
    #1;
    if (din_ack) prod_val++;
    if (dout_ack) begin
      check("stream_data", 64'(dout), 64'(cons_exp));
      cons_exp++;
    end
    if (int'(level) > peak_seen) peak_seen = int'(level);
  endtask

  typedef struct {
    logic          ack;
    logic [DW-1:0] din;
    logic          req;
    logic          e_din_req;
    logic          e_ack;
    logic [DW-1:0] e_dout;
    logic [AW:0]   e_level;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         4'd0};
    vecs[1] = '{1'b1, 32'h1111_0001, 1'b0, 1'b0, 1'b0, 32'h0,         4'd1};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h1111_0001, 4'd0};
    vecs[3] = '{1'b1, 32'h1111_0002, 1'b1, 1'b0, 1'b0, 32'h1111_0001, 4'd1};
    vecs[4] = '{1'b1, 32'hdead_beef, 1'b0, 1'b1, 1'b0, 32'h1111_0001, 4'd1};
    vecs[5] = '{1'b1, 32'h1111_0003, 1'b1, 1'b0, 1'b1, 32'h1111_0002, 4'd1};
    vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h1111_0002, 4'd1};
    vecs[7] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h1111_0003, 4'd0};
    vecs[8] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h1111_0003, 4'd0};

    rst = 1'b1;
    din_ack = 1'b0;
    dout_req = 1'b0;
    din = '0;
    prod_en = 0; cons_en = 0; prod_val = 0; cons_exp = 0; peak_seen = 0;

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_din_req", 64'(din_req), 64'd0);
    check("rst_dout_ack", 64'(dout_ack), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle upstream: request rises on first edge and stays up.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("idle_din_req", 64'(din_req), 64'd1);
      check("idle_dout_ack", 64'(dout_ack), 64'd0);
      check("idle_empty", 64'(empty), 64'd1);
    end

    // Directed vectors: single pushes/pops, spurious ack, simultaneous push and pop.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      din_ack  = vecs[i].ack;
      din      = vecs[i].din;
      dout_req = vecs[i].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_din_req", i), 64'(din_req), 64'(vecs[i].e_din_req));
      check($sformatf("vec%0d_dout_ack", i), 64'(dout_ack), 64'(vecs[i].e_ack));
      check($sformatf("vec%0d_dout", i), 64'(dout), 64'(vecs[i].e_dout));
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].e_level));
      check($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].e_level == 0));
      check($sformatf("vec%0d_full", i), 64'(full), 64'd0);
    end
`ifdef ACK_STREAM_FIFO_STATS_EN
    check("vec_push_count", 64'(push_count), 64'd3);
    check("vec_pop_count", 64'(pop_count), 64'd3);
    check("vec_peak", 64'(peak_level), 64'd1);
`endif

    // Fill to full with consumer stalled.
    do_reset();
    prod_en = 1; cons_en = 0; prod_val = 0; cons_exp = 0;
    for (int i = 0; i < 30; i++) cycle();
    check("fill_writes", 64'(prod_val), 64'd8);
    check("fill_level", 64'(level), 64'd8);
    check("fill_full", 64'(full), 64'd1);
    check("fill_din_req", 64'(din_req), 64'd0);
    @(negedge clk);
    din_ack = 1'b1;
    din = 32'h99;
    @(posedge clk);
    #1;
    check("full_spurious_level", 64'(level), 64'd8);
    prod_en = 0; cons_en = 1;
    cycle();
    check("drain_first_ack", 64'(dout_ack), 64'd1);
    check("drain_din_req", 64'(din_req), 64'd1);
    check("drain_level", 64'(level), 64'd7);
    for (int i = 0; i < 20; i++) cycle();
    check("drain_count", 64'(cons_exp), 64'd8);
    check("drain_empty", 64'(empty), 64'd1);

    // Long stream with no stalls on either side.
    do_reset();
    prod_en = 1; cons_en = 1; prod_val = 0; cons_exp = 0; peak_seen = 0;
    for (int i = 0; i < 30000 && cons_exp < 5000; i++) cycle();
    check("stream_count", 64'(cons_exp), 64'd5000);
    check("stream_peak_le2", 64'(peak_seen <= 2), 64'd1);

    // Simultaneous push and pop at level 3, then 20 words through a wrap.
    do_reset();
    prod_en = 1; cons_en = 0; prod_val = 0; cons_exp = 0;
    for (int i = 0; i < 40 && level < 3; i++) cycle();
    prod_en = 0;
    cycle();
    check("pp_pre_level", 64'(level), 64'd3);
    check("pp_pre_req", 64'(din_req), 64'd1);
    prod_en = 1; cons_en = 1;
    cycle();
    check("pp_level", 64'(level), 64'd3);
    check("pp_ack", 64'(dout_ack), 64'd1);
    for (int i = 0; i < 200 && cons_exp < 20; i++) begin
      prod_en = (prod_val < 20) ? 1 : 0;
      cycle();
    end
    check("wrap_count", 64'(cons_exp), 64'd20);
    check("wrap_empty", 64'(empty), 64'd1);

    // Reset at level 5 with a request outstanding; ack during reset is ignored.
    do_reset();
    prod_en = 1; cons_en = 0; prod_val = 0; cons_exp = 0;
    for (int i = 0; i < 40 && level < 5; i++) cycle();
    prod_en = 0;
    cycle();
    check("mid_pre_level", 64'(level), 64'd5);
    check("mid_pre_req", 64'(din_req), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    din_ack = 1'b1;
    din = 32'h77;
    @(posedge clk);
    #1;
    check("mid_level", 64'(level), 64'd0);
    check("mid_dout_ack", 64'(dout_ack), 64'd0);
    check("mid_din_req", 64'(din_req), 64'd0);
    check("mid_empty", 64'(empty), 64'd1);
`ifdef ACK_STREAM_FIFO_STATS_EN
    check("mid_push_count", 64'(push_count), 64'd0);
    check("mid_peak", 64'(peak_level), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    din_ack = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_req", 64'(din_req), 64'd1);
    check("post_rst_level", 64'(level), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
